// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder.
// Holds the CLA group width, the stage-count helper and the {G,P} pair
// type with its prefix-merge operator.
package msi_adder_pkg;

   localparam int CLA_GRP_W = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Number of register stages: one per GRP_PER_STG groups of CLA_GRP_W bits
   function automatic int cla_stages(input int width, input int grp_per_stg);
      return (width / CLA_GRP_W) / grp_per_stg;
   endfunction

   // Combine a higher {G,P} span with the adjacent lower span
   function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// Optional macro CLA_OVF_FLAG_EN adds the signed-overflow flag V.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             C_out;
`ifdef CLA_OVF_FLAG_EN
   logic             V;

   modport master (
      output in_valid, A, B, C_in, out_ready,
      input  in_ready, out_valid, S, C_out, V
   );

   modport slave (
      input  in_valid, A, B, C_in, out_ready,
      output in_ready, out_valid, S, C_out, V
   );
`else
   modport master (
      output in_valid, A, B, C_in, out_ready,
      input  in_ready, out_valid, S, C_out
   );

   modport slave (
      input  in_valid, A, B, C_in, out_ready,
      output in_ready, out_valid, S, C_out
   );
`endif
endinterface

// File: rtl/pipelined_cla_adder_group.sv
// One 4-bit carry-look-ahead group: sum bits from internal look-ahead
// carries plus group generate/propagate for the next look-ahead level.
module cla_4bit_group (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       g,
   output logic       p,
   output logic       co
);
   logic [3:0] gi;
   logic [3:0] pi;
   logic [3:0] c;

   assign gi = a & b;
   assign pi = a ^ b;

   // Every internal carry is a flat sum of products of gi/pi and ci
   assign c[0] = ci;
   assign c[1] = gi[0] | (pi[0] & ci);
   assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
   assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
               | (pi[2] & pi[1] & pi[0] & ci);

   assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
   assign p  = &pi;
   assign co = g | (p & ci);
   assign s  = pi ^ c;
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit carry-look-ahead adder.
// Stage k adds GRP_PER_STG 4-bit groups using the carry registered by
// stage k-1; upper operand slices are delayed and lower sum slices are
// carried forward so S leaves bit-aligned after STAGES register stages.
// The whole pipe advances on a single enable (no bubble squeezing).
// Optional macro CLA_OVF_FLAG_EN adds a registered signed-overflow flag V.
module pipelined_cla_adder
   import msi_adder_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int GRP_PER_STG = 1
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_cla_adder_if.slave bus
);
   localparam int NGRP   = WIDTH / CLA_GRP_W;
   localparam int STAGES = cla_stages(WIDTH, GRP_PER_STG);
   localparam int SW     = GRP_PER_STG * CLA_GRP_W;

   if ((WIDTH % CLA_GRP_W) != 0) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4");
   end
   if ((NGRP % GRP_PER_STG) != 0) begin : g_bad_split
      $error("pipelined_cla_adder: WIDTH/4 must be divisible by GRP_PER_STG");
   end

   logic              adv;
   logic [STAGES-1:0] vld_pipe;
   wire  [STAGES-1:0] cy_r;
   wire  [WIDTH-1:0]  s_out;
`ifdef CLA_OVF_FLAG_EN
   logic              v_q;
`endif

   // A held result freezes every stage at once
   assign adv          = !vld_pipe[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   // Valid shift register; bit k marks a live operand set leaving stage k
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else if (adv) begin
         vld_pipe <= STAGES'({vld_pipe, bus.in_valid});
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic                        cin_k;
      logic [SW-1:0]               a_k;
      logic [SW-1:0]               b_k;
      wire  [SW-1:0]               s_k;
      gp_t  [GRP_PER_STG-1:0]      gp;
      logic [GRP_PER_STG:0]        gc;
      wire  [GRP_PER_STG-1:0]      grp_co;
      logic                        unused_grp_co;
      logic [STAGES-k-1:0][SW-1:0] s_d;
      logic                        cy_q;

      if (k == 0) begin : g_in
         assign a_k   = bus.A[SW-1:0];
         assign b_k   = bus.B[SW-1:0];
         assign cin_k = bus.C_in;
      end else begin : g_dly
         logic [k-1:0][SW-1:0] a_d;
         logic [k-1:0][SW-1:0] b_d;

         // Delay this stage's operand slice k cycles to meet its carry
         always_ff @(posedge clk) begin
            if (rst) begin
               a_d <= '0;
               b_d <= '0;
            end else if (adv) begin
               a_d[0] <= bus.A[k*SW +: SW];
               b_d[0] <= bus.B[k*SW +: SW];
               for (int i = 1; i < k; i++) begin
                  a_d[i] <= a_d[i-1];
                  b_d[i] <= b_d[i-1];
               end
            end
         end

         assign a_k   = a_d[k-1];
         assign b_k   = b_d[k-1];
         assign cin_k = cy_r[k-1];
      end

      // Group carries from merged {G,P} prefixes of the lower groups
      always_comb begin
         gp_t acc;
         acc   = '0;
         gc    = '0;
         gc[0] = cin_k;
         for (int i = 0; i < GRP_PER_STG; i++) begin
            acc = gp[i];
            for (int j = i - 1; j >= 0; j--) begin
               acc = gp_merge(acc, gp[j]);
            end
            gc[i+1] = acc.g | (acc.p & cin_k);
         end
      end

      for (genvar g = 0; g < GRP_PER_STG; g++) begin : g_grp
         cla_4bit_group u_grp (
            .a  (a_k[g*CLA_GRP_W +: CLA_GRP_W]),
            .b  (b_k[g*CLA_GRP_W +: CLA_GRP_W]),
            .ci (gc[g]),
            .s  (s_k[g*CLA_GRP_W +: CLA_GRP_W]),
            .g  (gp[g].g),
            .p  (gp[g].p),
            .co (grp_co[g])
         );
      end

      // Per-group ripple outputs are redundant with the look-ahead carries
      assign unused_grp_co = ^grp_co;

      // Register the stage carry and push the sum slice toward the output
      always_ff @(posedge clk) begin
         if (rst) begin
            s_d  <= '0;
            cy_q <= 1'b0;
         end else if (adv) begin
            s_d[0] <= s_k;
            for (int i = 1; i < STAGES - k; i++) begin
               s_d[i] <= s_d[i-1];
            end
            cy_q <= gc[GRP_PER_STG];
         end
      end

      assign cy_r[k]            = cy_q;
      assign s_out[k*SW +: SW]  = s_d[STAGES-k-1];

`ifdef CLA_OVF_FLAG_EN
      if (k == STAGES - 1) begin : g_ovf
         // Carry into MSB is a^b^s at the MSB; XOR with carry out gives V
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
            end else if (adv) begin
               v_q <= a_k[SW-1] ^ b_k[SW-1] ^ s_k[SW-1] ^ gc[GRP_PER_STG];
            end
         end
      end
`endif
   end

   assign bus.out_valid = vld_pipe[STAGES-1];
   assign bus.S         = s_out;
   assign bus.C_out     = cy_r[STAGES-1];
`ifdef CLA_OVF_FLAG_EN
   assign bus.V         = v_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (16-bit, 1 group/stage) plus a
// randomized scoreboard run on a 32-bit, 2 groups/stage instance.
// Inputs change 1 time unit after a rising edge; a cycle index n means
// "observed after the n-th edge since the vector was first presented".
module tb_pipelined_cla_adder;
   localparam int W  = 16;
   localparam int W2 = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(W))  bus  ();
   pipelined_cla_adder_if #(.WIDTH(W2)) bus2 ();

   pipelined_cla_adder #(.WIDTH(W), .GRP_PER_STG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipelined_cla_adder #(.WIDTH(W2), .GRP_PER_STG(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
      bus.in_valid = v;
      bus.A        = a;
      bus.B        = b;
      bus.C_in     = c;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready  = 1'b1;
      drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
      bus2.in_valid  = 1'b0;
      bus2.A         = '0;
      bus2.B         = '0;
      bus2.C_in      = 1'b0;
      bus2.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
      end
      checks++;
      if ({bus.C_out, bus.S} !== 17'h0) begin
         errors++; $display("FAIL rst_sum got %h want 00000", {bus.C_out, bus.S});
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus2.out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid32 got %b want 0", bus2.out_valid);
      end
`ifdef CLA_OVF_FLAG_EN
      checks++;
      if (bus.V !== 1'b0) begin
         errors++; $display("FAIL rst_v got %b want 0", bus.V);
      end
`endif
   endtask

   // 3 + 10 + 1: result expected in cycle 4
   task automatic test_latency();
      int         first;
      logic [16:0] res;
      first = -1;
      res   = '0;
      drive(1'b1, 16'd3, 16'd10, 1'b1);
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (n == 1) drive(1'b0, 16'h0, 16'h0, 1'b0);
         if (bus.out_valid === 1'b1 && first < 0) begin
            first = n;
            res   = {bus.C_out, bus.S};
         end
      end
      checks++;
      if (first != 4) begin
         errors++; $display("FAIL latency got %0d want 4", first);
      end
      checks++;
      if (res !== {1'b0, 16'd14}) begin
         errors++; $display("FAIL latency_sum got %h want %h", res, {1'b0, 16'd14});
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic         vc [3];
      logic [16:0]  ex [3];
      int           got;
      va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; ex[0] = 17'h1_0000;
      va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b1; ex[1] = 17'h1_0001;
      va[2] = 16'h0000; vb[2] = 16'h0000; vc[2] = 1'b0; ex[2] = 17'h0_0000;
      got = 0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         if (t < 3) drive(1'b1, va[t], vb[t], vc[t]);
         else       drive(1'b0, 16'h0, 16'h0, 1'b0);
         tick();
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (got >= 3) begin
               errors++; $display("FAIL b2b_extra got result %0d want none", got);
            end else begin
               if ({bus.C_out, bus.S} !== ex[got]) begin
                  errors++; $display("FAIL b2b_sum%0d got %h want %h", got, {bus.C_out, bus.S}, ex[got]);
               end
               checks++;
               if (t != 3 + got) begin
                  errors++; $display("FAIL b2b_cycle%0d got %0d want %0d", got, t, 3 + got);
               end
            end
            got++;
         end
      end
      checks++;
      if (got != 3) begin
         errors++; $display("FAIL b2b_count got %0d want 3", got);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] va [6];
      logic [W-1:0] vb [6];
      logic         vc [6];
      logic [16:0]  ex [6];
      int           tx, rx, stalls;
      logic         fire, take;
      va[0] = 16'h1234; vb[0] = 16'h1111; vc[0] = 1'b0; ex[0] = 17'h0_2345;
      va[1] = 16'hF000; vb[1] = 16'h1000; vc[1] = 1'b1; ex[1] = 17'h1_0001;
      va[2] = 16'h00FF; vb[2] = 16'h0001; vc[2] = 1'b0; ex[2] = 17'h0_0100;
      va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vc[3] = 1'b1; ex[3] = 17'h1_FFFF;
      va[4] = 16'h0F0F; vb[4] = 16'hF0F0; vc[4] = 1'b1; ex[4] = 17'h1_0000;
      va[5] = 16'h7FFF; vb[5] = 16'h7FFF; vc[5] = 1'b0; ex[5] = 17'h0_FFFE;
      tx = 0; rx = 0; stalls = 0;
      for (int t = 0; t < 40 && rx < 6; t++) begin
         bus.out_ready = !(t >= 6 && t < 11);
         if (tx < 6) drive(1'b1, va[tx], vb[tx], vc[tx]);
         else        drive(1'b0, 16'h0, 16'h0, 1'b0);
         #1;
         fire = bus.in_valid && bus.in_ready;
         take = bus.out_valid && bus.out_ready;
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (rx >= 6) begin
               errors++; $display("FAIL bp_extra got result %0d want none", rx);
            end else if ({bus.C_out, bus.S} !== ex[rx]) begin
               errors++; $display("FAIL bp_sum%0d got %h want %h", rx, {bus.C_out, bus.S}, ex[rx]);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            stalls++;
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready);
            end
         end
         @(posedge clk);
         #1;
         if (fire) tx++;
         if (take) rx++;
      end
      bus.out_ready = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      checks++;
      if (rx != 6 || tx != 6) begin
         errors++; $display("FAIL bp_count got tx %0d rx %0d want 6 6", tx, rx);
      end
      checks++;
      if (stalls != 5) begin
         errors++; $display("FAIL bp_stalls got %0d want 5", stalls);
      end
      for (int n = 0; n < 6; n++) tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drained got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      int          seen, first;
      logic [16:0] res;
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h1111, 16'h2222, 1'b0); tick();
      drive(1'b1, 16'h3333, 16'h4444, 1'b1); tick();
      drive(1'b1, 16'h5555, 16'h6666, 1'b0); tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid);
      end
      seen = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (bus.out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL mid_rst_quiet got %0d valid cycles want 0", seen);
      end
      first = -1;
      res   = '0;
      drive(1'b1, 16'd12, 16'd10, 1'b1);
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (n == 1) drive(1'b0, 16'h0, 16'h0, 1'b0);
         if (bus.out_valid === 1'b1 && first < 0) begin
            first = n;
            res   = {bus.C_out, bus.S};
         end
      end
      checks++;
      if (first != 4) begin
         errors++; $display("FAIL mid_rst_latency got %0d want 4", first);
      end
      checks++;
      if (res !== {1'b0, 16'd23}) begin
         errors++; $display("FAIL mid_rst_sum got %h want %h", res, {1'b0, 16'd23});
      end
   endtask

`ifdef CLA_OVF_FLAG_EN
   task automatic test_overflow();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [17:0]  ex [3];
      int           got;
      // expected packed as {V, C_out, S}
      va[0] = 16'h7FFF; vb[0] = 16'h0001; ex[0] = {1'b1, 1'b0, 16'h8000};
      va[1] = 16'h8000; vb[1] = 16'hFFFF; ex[1] = {1'b1, 1'b1, 16'h7FFF};
      va[2] = 16'h0005; vb[2] = 16'h0003; ex[2] = {1'b0, 1'b0, 16'h0008};
      got = 0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         if (t < 3) drive(1'b1, va[t], vb[t], 1'b0);
         else       drive(1'b0, 16'h0, 16'h0, 1'b0);
         tick();
         if (bus.out_valid === 1'b1 && got < 3) begin
            checks++;
            if ({bus.V, bus.C_out, bus.S} !== ex[got]) begin
               errors++; $display("FAIL ovf%0d got %h want %h", got, {bus.V, bus.C_out, bus.S}, ex[got]);
            end
            got++;
         end
      end
      checks++;
      if (got != 3) begin
         errors++; $display("FAIL ovf_count got %0d want 3", got);
      end
   endtask
`endif

   task automatic test_wide_random();
      logic [W2:0] sb [$];
      logic [W2:0] exp_v;
      logic        fire, take;
      int          nres;
      nres = 0;
      for (int t = 0; t < 3000; t++) begin
         bus2.in_valid  = ($urandom_range(0, 3) != 0);
         bus2.A         = $urandom;
         bus2.B         = $urandom;
         bus2.C_in      = 1'($urandom_range(0, 1));
         bus2.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         fire = bus2.in_valid && bus2.in_ready;
         take = bus2.out_valid && bus2.out_ready;
         if (take) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL wide_extra got %h want none", {bus2.C_out, bus2.S});
            end else begin
               exp_v = sb.pop_front();
               nres++;
               if ({bus2.C_out, bus2.S} !== exp_v) begin
                  errors++; $display("FAIL wide_sum%0d got %h want %h", nres, {bus2.C_out, bus2.S}, exp_v);
               end
            end
         end
         if (fire) sb.push_back({1'b0, bus2.A} + {1'b0, bus2.B} + {{W2{1'b0}}, bus2.C_in});
         @(posedge clk);
         #1;
      end
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (bus2.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL wide_extra got %h want none", {bus2.C_out, bus2.S});
            end else begin
               exp_v = sb.pop_front();
               if ({bus2.C_out, bus2.S} !== exp_v) begin
                  errors++; $display("FAIL wide_drain got %h want %h", {bus2.C_out, bus2.S}, exp_v);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL wide_lost got %0d pending want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
`ifdef CLA_OVF_FLAG_EN
      test_overflow();
`endif
      test_wide_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
